// File: rtl/dmem_pkg.sv
// Shared constants and types for the byte-addressable data memory.
package dmem_pkg;

    // RV32 load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Width of the response wait counter (WAIT_CYCLES up to 15)
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering, load extension and access legality checking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be_c,
    output logic [31:0] wdata_rep_c,
    output logic [31:0] rdata_ext_c,
    output logic        err_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Decode access size, build lane enables and extend the selected load lane
    always_comb begin
        be_c        = 4'b0000;
        wdata_rep_c = wdata;
        rdata_ext_c = 32'd0;
        err_c       = 1'b0;
        byte_sel    = rword[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];

        case (funct3)
            F3_B: begin
                be_c        = 4'b0001 << addr_lo;
                wdata_rep_c = {4{wdata[7:0]}};
                rdata_ext_c = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                err_c       = addr_lo[0];
                be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata[15:0]}};
                rdata_ext_c = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                err_c       = (addr_lo != 2'b00);
                be_c        = 4'b1111;
                rdata_ext_c = rword;
            end
            F3_BU: begin
                err_c       = we;
                rdata_ext_c = {24'd0, byte_sel};
            end
            F3_HU: begin
                err_c       = we | addr_lo[0];
                rdata_ext_c = {16'd0, half_sel};
            end
            default: begin
                err_c = 1'b1;
            end
        endcase

        // Errors never write; stores and errors return zero data
        if (err_c || !we) begin
            be_c = 4'b0000;
        end
        if (err_c || we) begin
            rdata_ext_c = 32'd0;
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Byte-addressable RV32 data memory with request/response handshake and
// configurable response latency.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned IDX_W = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    // Storage starts zeroed and is deliberately untouched by rst
    logic [31:0] mem [DEPTH] = '{default: 32'd0};

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      rword;
    logic [3:0]       be_c;
    logic [31:0]      wdata_rep_c;
    logic [31:0]      rdata_ext_c;
    logic             err_c;
    logic             accept_c;

    assign word_idx  = req_addr[ADDR_WIDTH-1:2];
    assign rword     = mem[word_idx];
    assign req_ready = (state == IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;

    dmem_lane_align u_align (
        .we          (req_we),
        .funct3      (req_funct3),
        .addr_lo     (req_addr[1:0]),
        .wdata       (req_wdata),
        .rword       (rword),
        .be_c        (be_c),
        .wdata_rep_c (wdata_rep_c),
        .rdata_ext_c (rdata_ext_c),
        .err_c       (err_c)
    );

    // Commit enabled store lanes on the accept edge
    always_ff @(posedge clk) begin
        if (accept_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep_c[8*b +: 8];
                end
            end
        end
    end

    // Request/response sequencing with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        rsp_rdata <= rdata_ext_c;
                        rsp_err   <= err_c;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: two instances (no wait / three wait cycles) checked
// against a byte-array reference model.
module tb_data_mem_ctrl;
    import dmem_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [11:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    logic [7:0]  mm [2][4096];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc    = 0;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference: legality from access size and alignment
    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [11:0] a);
        if (we && f3 > 3'd2) return 1'b1;
        if (!we && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
        if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
        if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input int sel, input logic [2:0] f3, input logic [11:0] a);
        int ai = int'(a);
        logic [7:0] b0, b1, b2, b3;
        b0 = mm[sel][ai];
        b1 = (ai + 1 < 4096) ? mm[sel][ai+1] : 8'd0;
        b2 = (ai + 2 < 4096) ? mm[sel][ai+2] : 8'd0;
        b3 = (ai + 3 < 4096) ? mm[sel][ai+3] : 8'd0;
        case (f3)
            3'd0: return {{24{b0[7]}}, b0};
            3'd1: return {{16{b1[7]}}, b1, b0};
            3'd2: return {b3, b2, b1, b0};
            3'd4: return {24'd0, b0};
            3'd5: return {16'd0, b1, b0};
            default: return 32'd0;
        endcase
    endfunction

    // Apply the request about to be accepted at the coming edge to the model
    task automatic model_accept(input int sel, input bit expect_rsp);
        exp_t e;
        logic [11:0] a = req_addr[sel];
        logic [2:0]  f = req_funct3[sel];
        e.err   = model_err(req_we[sel], f, a);
        e.rdata = (e.err || req_we[sel]) ? 32'd0 : model_load(sel, f, a);
        e.cyc   = 32'(cyc + 1 + (sel == 1 ? 3 : 0));
        if (req_we[sel] && !e.err) begin
            for (int k = 0; k < (1 << f[1:0]); k++)
                mm[sel][int'(a) + k] = req_wdata[sel][8*k +: 8];
        end
        if (expect_rsp) begin
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic issue(input int sel, input logic we, input logic [2:0] f3,
                         input logic [11:0] a, input logic [31:0] wd,
                         input bit expect_rsp, input bit hold);
        int t = 0;
        @(negedge clk);
        req_valid[sel] = 1'b1; req_we[sel] = we; req_funct3[sel] = f3;
        req_addr[sel] = a;     req_wdata[sel] = wd;
        while (!req_ready[sel]) begin
            @(negedge clk);
            t++;
            if (t > 50) begin
                checks++;
                $display("FAIL ready_timeout: dut%0d req_ready stayed 0", sel);
                req_valid[sel] = 1'b0;
                return;
            end
        end
        model_accept(sel, expect_rsp);
        @(posedge clk);
        #1;
        if (!hold) req_valid[sel] = 1'b0;
    endtask

    task automatic mon(input int sel);
        exp_t e;
        if (rsp_valid[sel]) begin
            if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
                checks++;
                $display("FAIL unexpected_rsp: dut%0d rsp_valid=1 expected no response", sel);
            end else begin
                e = (sel == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rsp_rdata%0d", sel), rsp_rdata[sel], e.rdata);
                chk($sformatf("rsp_err%0d", sel), 32'(rsp_err[sel]), 32'(e.err));
                chk($sformatf("rsp_cycle%0d", sel), 32'(cyc), e.cyc);
            end
        end
    endtask

    // Monitor: compare every response pulse against the scoreboard
    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0; req_we[s] = 1'b0; req_funct3[s] = 3'd0;
            req_addr[s] = 12'd0; req_wdata[s] = 32'd0;
            for (int i = 0; i < 4096; i++) mm[s][i] = 8'd0;
        end

        // Reset behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_rst0", 32'(req_ready[0]), 32'd0);
        chk("ready_in_rst1", 32'(req_ready[1]), 32'd0);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("ready_after_rst", 32'(req_ready[s]), 32'd1);
            chk("rsp_valid_rst", 32'(rsp_valid[s]), 32'd0);
            chk("rsp_rdata_rst", rsp_rdata[s], 32'd0);
            chk("rsp_err_rst", 32'(rsp_err[s]), 32'd0);
        end

        // Directed sequence, no wait states
        issue(0, 1, F3_W,  12'h004, 32'hA1B2C3D4, 1, 0);
        issue(0, 0, F3_W,  12'h004, 32'h0, 1, 0);
        issue(0, 1, F3_B,  12'h005, 32'h000000FF, 1, 0);
        issue(0, 0, F3_W,  12'h004, 32'h0, 1, 0);
        issue(0, 0, F3_B,  12'h005, 32'h0, 1, 0);
        issue(0, 0, F3_BU, 12'h005, 32'h0, 1, 0);
        issue(0, 0, F3_H,  12'h006, 32'h0, 1, 0);
        issue(0, 0, F3_HU, 12'h006, 32'h0, 1, 0);
        issue(0, 0, F3_H,  12'h004, 32'h0, 1, 0);
        issue(0, 1, F3_W,  12'h006, 32'h12345678, 1, 0);
        issue(0, 0, F3_W,  12'h004, 32'h0, 1, 0);
        issue(0, 0, 3'd3,  12'h004, 32'h0, 1, 0);
        chk("model_word4", {mm[0][7], mm[0][6], mm[0][5], mm[0][4]}, 32'hA1B2FFD4);

        // Randomised traffic, no wait states
        for (int n = 0; n < 60; n++)
            issue(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  12'($urandom_range(0, 63)), $urandom, 1, 0);

        // Wait states: held request is not re-accepted until IDLE
        issue(1, 1, F3_W, 12'h004, 32'hCAFEF00D, 1, 0);
        issue(1, 0, F3_W, 12'h004, 32'h0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready[1]), 32'd0);
        end
        @(negedge clk);
        chk("ready_idle_again", 32'(req_ready[1]), 32'd1);
        model_accept(1, 1);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;

        // Reset during WAIT drops the response but keeps the store
        issue(1, 1, F3_W, 12'h008, 32'h0000BEEF, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_rst_mid", 32'(req_ready[1]), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_mid_rst", 32'(req_ready[1]), 32'd1);
        repeat (8) @(negedge clk);
        issue(1, 0, F3_W, 12'h008, 32'h0, 1, 0);

        // Randomised traffic with wait states
        for (int n = 0; n < 40; n++)
            issue(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  12'($urandom_range(0, 63)), $urandom, 1, 0);

        // Drain the scoreboard
        for (int t = 0; t < 100 && (q0.size() != 0 || q1.size() != 0); t++)
            @(negedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
